// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle job scheduler and its arbiter.
package tri_pkg;
  localparam int DATA_W = 32;

  localparam logic [1:0] ADDR_A   = 2'd0;
  localparam logic [1:0] ADDR_B   = 2'd1;
  localparam logic [1:0] ADDR_C   = 2'd2;
  localparam logic [1:0] ADDR_RES = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_B,
    WR_C,
    RD,
    RD_DATA,
    RESP
  } state_t;
endpackage

// File: rtl/tri_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index,
// which resets to NREQ-1 so that requester 0 wins first after reset.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic                    en,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] index
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] last_reg;
  logic [IW-1:0] idx;
  logic          found;
  int            j;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    j     = 0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last_reg) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = IW'(j);
      if (en && req[idx] && !found) begin
        grant[idx] = 1'b1;
        index      = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_reg <= IW'(NREQ - 1);
    else if (found) last_reg <= index;
  end
endmodule

// File: rtl/tri_job_scheduler.sv
// Triangle job scheduler: arbitrates requesters and runs each job as three
// Avalon-MM writes plus one read. TRI_JOB_SCHED_TIMEOUT_EN adds a stall timeout.
module tri_job_scheduler
  import tri_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*DATA_W-1:0] req_c,
  output logic [NREQ-1:0]        rsp_valid,
  output logic                   rsp_result,
  output logic                   rsp_error,
  output logic                   busy,
  output logic [1:0]             avm_address,
  output logic                   avm_read,
  output logic                   avm_write,
  output logic [DATA_W-1:0]      avm_writedata,
  input  logic                   avm_waitrequest,
  input  logic [DATA_W-1:0]      avm_readdata
);
  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] a_reg, a_next, b_reg, b_next, c_reg, c_next;
  logic [IW-1:0]     g_reg, g_next;
  logic              result_reg, result_next;
  logic              rst_done_reg;
  logic              arb_en;
  logic [NREQ-1:0]   arb_grant;
  logic [IW-1:0]     arb_index;
  logic [DATA_W-1:0] a_arr [NREQ];
  logic [DATA_W-1:0] b_arr [NREQ];
  logic [DATA_W-1:0] c_arr [NREQ];
  logic              readdata_unused;

  assign readdata_unused = ^avm_readdata[DATA_W-1:1];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
      assign b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
      assign c_arr[gi] = req_c[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Grants are held off for the first cycle after reset so req_ready stays 0 during reset.
  assign arb_en = (state_reg == IDLE) && rst_done_reg;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .en      (arb_en),
    .grant   (arb_grant),
    .index   (arb_index)
  );

`ifdef TRI_JOB_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          error_reg, error_next;
`else
  localparam int timeout_unused = TIMEOUT;
`endif

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    c_next        = c_reg;
    g_next        = g_reg;
    result_next   = result_reg;
    avm_address   = ADDR_A;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = '0;
`ifdef TRI_JOB_SCHED_TIMEOUT_EN
    cnt_next      = cnt_reg;
    error_next    = error_reg;
`endif
    case (state_reg)
      IDLE: if (|arb_grant) begin
        a_next      = a_arr[arb_index];
        b_next      = b_arr[arb_index];
        c_next      = c_arr[arb_index];
        g_next      = arb_index;
        result_next = 1'b0;
`ifdef TRI_JOB_SCHED_TIMEOUT_EN
        error_next  = 1'b0;
        cnt_next    = '0;
`endif
        state_next  = WR_A;
      end
      WR_A: begin
        avm_write = 1'b1; avm_address = ADDR_A; avm_writedata = a_reg;
        if (!avm_waitrequest) state_next = WR_B;
      end
      WR_B: begin
        avm_write = 1'b1; avm_address = ADDR_B; avm_writedata = b_reg;
        if (!avm_waitrequest) state_next = WR_C;
      end
      WR_C: begin
        avm_write = 1'b1; avm_address = ADDR_C; avm_writedata = c_reg;
        if (!avm_waitrequest) state_next = RD;
      end
      RD: begin
        avm_read = 1'b1; avm_address = ADDR_RES;
        if (!avm_waitrequest) state_next = RD_DATA;
      end
      RD_DATA: begin
        result_next = avm_readdata[0];
        state_next  = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
`ifdef TRI_JOB_SCHED_TIMEOUT_EN
    // Abort on the TIMEOUT-th consecutive stalled cycle of any transfer.
    if (avm_read || avm_write) begin
      if (!avm_waitrequest) cnt_next = '0;
      else if (cnt_reg == CW'(TIMEOUT - 1)) begin
        cnt_next    = '0;
        error_next  = 1'b1;
        result_next = 1'b0;
        state_next  = RESP;
      end else cnt_next = cnt_reg + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      c_reg        <= '0;
      g_reg        <= '0;
      result_reg   <= 1'b0;
      rst_done_reg <= 1'b0;
`ifdef TRI_JOB_SCHED_TIMEOUT_EN
      cnt_reg      <= '0;
      error_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      c_reg        <= c_next;
      g_reg        <= g_next;
      result_reg   <= result_next;
      rst_done_reg <= 1'b1;
`ifdef TRI_JOB_SCHED_TIMEOUT_EN
      cnt_reg      <= cnt_next;
      error_reg    <= error_next;
`endif
    end
  end

  assign req_ready  = arb_grant;
  assign busy       = (state_reg != IDLE);
  assign rsp_valid  = (state_reg == RESP) ? (ONE << g_reg) : '0;
  assign rsp_result = (state_reg == RESP) && result_reg;
`ifdef TRI_JOB_SCHED_TIMEOUT_EN
  assign rsp_error  = (state_reg == RESP) && error_reg;
`else
  assign rsp_error  = 1'b0;
`endif
endmodule

// File: tb/tb_tri_job_scheduler.sv
// Directed bench for tri_job_scheduler with a stalling Avalon slave model that
// computes the triangle bit. The timeout case runs when TRI_JOB_SCHED_TIMEOUT_EN is defined.
module tb_tri_job_scheduler;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b, req_c;
  logic [3:0]   rsp_valid;
  logic         rsp_result, rsp_error, busy;
  logic [1:0]   avm_address;
  logic         avm_read, avm_write;
  logic [31:0]  avm_writedata;
  logic         avm_waitrequest;
  logic [31:0]  avm_readdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tri_job_scheduler #(.NREQ(4), .TIMEOUT(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_a           (req_a),
    .req_b           (req_b),
    .req_c           (req_c),
    .rsp_valid       (rsp_valid),
    .rsp_result      (rsp_result),
    .rsp_error       (rsp_error),
    .busy            (busy),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: optional stall count per transfer, memory for A/B/C, triangle read-back.
  int          stall_n = 0;
  int          wcnt = 0;
  bit          stab_en = 1'b0;
  bit          prev_wait = 1'b0;
  logic [35:0] prev_bus;
  logic [31:0] mem [4];
  logic [35:0] log_q [$];

  function automatic logic tri_ok(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return ({1'b0, a} + {1'b0, b} > {1'b0, c}) && ({1'b0, a} + {1'b0, c} > {1'b0, b}) &&
           ({1'b0, b} + {1'b0, c} > {1'b0, a});
  endfunction

  always @(negedge clk) begin
    if (avm_read || avm_write) begin
      if (wcnt < stall_n) begin avm_waitrequest = 1'b1; wcnt++; end
      else begin avm_waitrequest = 1'b0; wcnt = 0; end
    end else begin
      avm_waitrequest = 1'b0; wcnt = 0;
    end
    #1;
    if (stab_en && prev_wait && (avm_read || avm_write))
      check("stall_hold", {avm_address, avm_read, avm_write, avm_writedata}, prev_bus);
    prev_wait = avm_waitrequest && (avm_read || avm_write);
    prev_bus  = {avm_address, avm_read, avm_write, avm_writedata};
    if (avm_write && !avm_waitrequest) begin
      mem[avm_address] = avm_writedata;
      log_q.push_back({avm_address, 2'b01, avm_writedata});
    end
    if (avm_read && !avm_waitrequest) begin
      log_q.push_back({avm_address, 2'b10, 32'd0});
      avm_readdata = {31'd0, tri_ok(mem[0], mem[1], mem[2])};
    end
  end

  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_c[r*32 +: 32] = c;
  endtask

  task automatic wait_ready(output logic [3:0] rdy);
    rdy = '0;
    for (int n = 0; n < 300; n++) begin
      if (n > 0) begin step(); #1; end
      if (|req_ready) begin rdy = req_ready; break; end
    end
  endtask

  // Called in the cycle after the grant; lat is grant-to-response inclusive.
  task automatic wait_rsp(output logic [3:0] v, output logic res, output logic err, output int lat);
    v = '0; res = 1'b0; err = 1'b0; lat = -1;
    for (int n = 0; n < 300; n++) begin
      if (n > 0) begin step(); #1; end
      if (|rsp_valid) begin
        v = rsp_valid; res = rsp_result; err = rsp_error; lat = n + 2; break;
      end
    end
  endtask

  task automatic run_job(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic exp_res, input int exp_lat);
    logic [3:0] v, exp_oh;
    logic       res, err;
    int         lat;
    exp_oh = 4'b0001 << r;
    log_q.delete();
    step();
    set_ops(r, a, b, c);
    req_valid = exp_oh;
    #1;
    check("grant", req_ready, exp_oh);
    step();
    req_valid = '0;
    set_ops(r, 32'hdead_beef, 32'h1, 32'h2);
    #1;
    wait_rsp(v, res, err, lat);
    check("rsp_valid", v, exp_oh);
    check("rsp_result", res, exp_res);
    check("rsp_error", err, 1'b0);
    check("latency", lat, exp_lat);
    check("xfer_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("xfer_a", log_q[0], {2'd0, 2'b01, a});
      check("xfer_b", log_q[1], {2'd1, 2'b01, b});
      check("xfer_c", log_q[2], {2'd2, 2'b01, c});
      check("xfer_rd", log_q[3], {2'd3, 2'b10, 32'd0});
    end
    step(); #1;
    check("idle_after", busy, 1'b0);
    $display("job r=%0d ops=(%0d,%0d,%0d) rsp=%b result=%b lat=%0d", r, a, b, c, v, res, lat);
  endtask

  initial begin
    logic [3:0]  rdy, v;
    logic        res, err;
    int          lat, seen;
    logic [31:0] oa [4];
    logic [31:0] ob [4];
    logic [31:0] oc [4];
    logic        er [4];
    oa = '{32'd3, 32'd1, 32'd5, 32'd1};
    ob = '{32'd4, 32'd2, 32'd5, 32'd1};
    oc = '{32'd5, 32'd3, 32'd5, 32'd10};
    er = '{1'b1, 1'b0, 1'b1, 1'b0};
    req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0;

    repeat (3) @(negedge clk);
    #3;
    check("reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_error, busy,
                            avm_address, avm_read, avm_write, avm_writedata}, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // All four requesters at once: round-robin from 0.
    step();
    for (int r = 0; r < 4; r++) set_ops(r, oa[r], ob[r], oc[r]);
    req_valid = 4'hf;
    #1;
    for (int g = 0; g < 4; g++) begin
      wait_ready(rdy);
      check("rr_grant", rdy, 4'b0001 << g);
      step();
      req_valid[g] = 1'b0;
      #1;
      wait_rsp(v, res, err, lat);
      check("rr_rsp_valid", v, 4'b0001 << g);
      check("rr_rsp_result", res, er[g]);
      $display("rr job g=%0d grant=%b rsp=%b result=%b", g, rdy, v, res);
      step(); #1;
    end

    run_job(0, 32'd3, 32'd4, 32'd5, 1'b1, 7);
    run_job(1, 32'd1, 32'd2, 32'd3, 1'b0, 7);

    stall_n = 5; stab_en = 1'b1;
    run_job(2, 32'd7, 32'd10, 32'd5, 1'b1, 27);
    stab_en = 1'b0; stall_n = 0;

    // Reset in the middle of the WR_B transfer.
    step();
    set_ops(2, 32'd3, 32'd4, 32'd5);
    req_valid = 4'b0100;
    #1;
    check("mid_grant", req_ready, 4'b0100);
    step(); req_valid = '0; #1;
    step(); #1;
    check("in_wr_b", {avm_write, avm_address, avm_writedata}, {1'b1, 2'd1, 32'd4});
    reset_n = 1'b0;
    req_valid = 4'b1000;
    #1;
    check("mid_reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_error, busy,
                                avm_address, avm_read, avm_write, avm_writedata}, '0);
    step(); #1;
    check("held_reset_outputs", {req_ready, busy, avm_read, avm_write}, '0);
    step();
    req_valid = '0;
    reset_n = 1'b1;
    seen = 0;
    repeat (10) begin step(); #1; if (|rsp_valid) seen++; end
    check("no_rsp_after_reset", seen, 0);
    $display("reset mid WR_B: responses after release=%0d", seen);
    run_job(3, 32'd6, 32'd8, 32'd10, 1'b1, 7);

`ifdef TRI_JOB_SCHED_TIMEOUT_EN
    stall_n = 100000;
    step();
    set_ops(0, 32'd3, 32'd4, 32'd5);
    req_valid = 4'b0001;
    #1;
    check("to_grant", req_ready, 4'b0001);
    step(); req_valid = '0; #1;
    wait_rsp(v, res, err, lat);
    check("to_rsp_valid", v, 4'b0001);
    check("to_rsp_error", err, 1'b1);
    check("to_rsp_result", res, 1'b0);
    check("to_latency", lat, 10);
    step(); #1;
    check("to_idle", {busy, avm_read, avm_write}, 3'b000);
    $display("timeout job rsp=%b error=%b lat=%0d", v, err, lat);
    stall_n = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
